// File: rtl/avmm_pio_pkg.sv
// Shared encodings for the Avalon-MM PIO master: command opcodes, response
// status codes and the transaction state enum.
package avmm_pio_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_TIMEOUT = 2'b01,
        RSP_BAD_OP  = 2'b10
    } rsp_status_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDWAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/avmm_pio_master_if.sv
// Command, response and Avalon-MM bus signals of the PIO master, bundled.
// The master modport is the block's view; the slave modport is its environment.
interface avmm_pio_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        output cmd_ready,
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest,
        output rsp_valid, rsp_data, rsp_status,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask,
        input  cmd_ready,
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest,
        input  rsp_valid, rsp_data, rsp_status,
        output rsp_ready
    );

endinterface

// File: rtl/avmm_rd_latency_tracker.sv
// Delays the read-accept pulse by LATENCY cycles so the master samples
// avm_readdata exactly when the fixed-latency slave presents it.
module avmm_rd_latency_tracker #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic accept,
    output logic sample
);

    logic [LATENCY-1:0] pipe_q;
    logic [LATENCY-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | LATENCY'(accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign sample = pipe_q[LATENCY-1];

endmodule

// File: rtl/avmm_pio_master.sv
// Single-outstanding Avalon-MM PIO master executing write/read/poll commands.
// Define AVMM_PIO_MASTER_POLL_EN to build the poll op, attempt counter and TIMEOUT status.
module avmm_pio_master
    import avmm_pio_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int POLL_TIMEOUT = 1024
) (
    input logic               clk,
    input logic               reset,
    avmm_pio_master_if.master bus
);

    state_e            state_q, state_d;
    cmd_op_e           op_q, op_d;
    cmd_op_e           cmd_op_in;
    logic [ADDR_W-1:0] avm_address_q, avm_address_d;
    logic [DATA_W-1:0] avm_writedata_q, avm_writedata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    rsp_status_e       rsp_status_q, rsp_status_d;
    logic              avm_read_q, avm_read_d;
    logic              avm_write_q, avm_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              op_ok;
    logic              rd_accept;
    logic              rd_sample;

`ifdef AVMM_PIO_MASTER_POLL_EN
    localparam int CNT_W = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST_ATTEMPT = CNT_W'(POLL_TIMEOUT - 1);

    logic [CNT_W-1:0]  attempt_q, attempt_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic              poll_miss;
`else
    logic unused_poll;
    assign unused_poll = ^{bus.cmd_mask, POLL_TIMEOUT[0]};
`endif

    assign rd_accept = (state_q == ST_ISSUE) && avm_read_q && !bus.avm_waitrequest;

    avmm_rd_latency_tracker #(
        .LATENCY (READ_LATENCY)
    ) u_rd_lat (
        .clk    (clk),
        .reset  (reset),
        .accept (rd_accept),
        .sample (rd_sample)
    );

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        rsp_data_d      = rsp_data_q;
        rsp_status_d    = rsp_status_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        rsp_valid_d     = rsp_valid_q;
        cmd_op_in       = cmd_op_e'(bus.cmd_op);
`ifdef AVMM_PIO_MASTER_POLL_EN
        attempt_d       = attempt_q;
        mask_d          = mask_q;
        poll_miss       = ((bus.avm_readdata ^ avm_writedata_q) & mask_q) != '0;
        op_ok           = (cmd_op_in != OP_RSVD);
`else
        op_ok           = (cmd_op_in == OP_WRITE) || (cmd_op_in == OP_READ);
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d            = cmd_op_in;
                    avm_address_d   = bus.cmd_addr;
                    avm_writedata_d = bus.cmd_wdata;
`ifdef AVMM_PIO_MASTER_POLL_EN
                    mask_d          = bus.cmd_mask;
                    attempt_d       = '0;
`endif
                    if (op_ok) begin
                        state_d     = ST_ISSUE;
                        avm_write_d = (cmd_op_in == OP_WRITE);
                        avm_read_d  = (cmd_op_in != OP_WRITE);
                    end else begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_status_d = RSP_BAD_OP;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (op_q == OP_WRITE) begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = avm_writedata_q;
                        rsp_status_d = RSP_OK;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                if (rd_sample) begin
                    rsp_data_d   = bus.avm_readdata;
                    rsp_status_d = RSP_OK;
                    state_d      = ST_RESP;
                    rsp_valid_d  = 1'b1;
`ifdef AVMM_PIO_MASTER_POLL_EN
                    // A missed poll re-issues straight from here; the read
                    // latency window already left the bus idle in between.
                    if (op_q == OP_POLL && poll_miss) begin
                        if (attempt_q == LAST_ATTEMPT) begin
                            rsp_status_d = RSP_TIMEOUT;
                        end else begin
                            attempt_d   = attempt_q + CNT_W'(1);
                            state_d     = ST_ISSUE;
                            rsp_valid_d = 1'b0;
                            avm_read_d  = 1'b1;
                        end
                    end
`endif
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            op_q            <= OP_WRITE;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            rsp_data_q      <= '0;
            rsp_status_q    <= RSP_OK;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            cmd_ready_q     <= 1'b0;
`ifdef AVMM_PIO_MASTER_POLL_EN
            attempt_q       <= '0;
            mask_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            rsp_data_q      <= rsp_data_d;
            rsp_status_q    <= rsp_status_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            rsp_valid_q     <= rsp_valid_d;
            cmd_ready_q     <= cmd_ready_d;
`ifdef AVMM_PIO_MASTER_POLL_EN
            attempt_q       <= attempt_d;
            mask_q          <= mask_d;
`endif
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_status    = rsp_status_q;

endmodule

// File: tb/tb_avmm_pio_master.sv
// Directed bench for avmm_pio_master: a fixed-latency slave model plus a bus
// monitor; every expected value below is hand-computed.
module tb_avmm_pio_master;

    localparam int ADDR_W       = 2;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 1;
    localparam int POLL_TIMEOUT = 6;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    avmm_pio_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avmm_pio_master #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY),
        .POLL_TIMEOUT (POLL_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    int wr_hi = 0, wr_done = 0, rd_hi = 0, rd_done = 0;
    int rsp_count = 0, bus_bad = 0, b2b = 0;
    int rd_base = 0;
    logic prev_rd_acc = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic [DATA_W-1:0] rd_vals [16];

    // Slave model (read data one cycle after acceptance) and bus monitor.
    always @(posedge clk) begin
        if (reset) begin
            prev_rd_acc <= 1'b0;
        end else begin
            if (bus.avm_write) begin
                wr_hi <= wr_hi + 1;
                if (bus.avm_address !== exp_addr || bus.avm_writedata !== exp_wdata || bus.avm_read)
                    bus_bad <= bus_bad + 1;
                if (!bus.avm_waitrequest) wr_done <= wr_done + 1;
            end
            if (bus.avm_read) begin
                rd_hi <= rd_hi + 1;
                if (bus.avm_address !== exp_addr) bus_bad <= bus_bad + 1;
                if (prev_rd_acc) b2b <= b2b + 1;
                if (!bus.avm_waitrequest) begin
                    rd_done          <= rd_done + 1;
                    bus.avm_readdata <= rd_vals[(rd_done - rd_base) & 15];
                end
            end
            prev_rd_acc <= bus.avm_read && !bus.avm_waitrequest;
            if (bus.rsp_valid && bus.rsp_ready) rsp_count <= rsp_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] mask);
        int n;
        n = 0;
        @(negedge clk);
        exp_addr      = addr;
        exp_wdata     = wdata;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_mask  = mask;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic getResponse(input int hold, output logic [DATA_W-1:0] data,
                               output logic [1:0] status, output int lat);
        int changes;
        int rdy_hi;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 200);
        checkOutput("rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
        data    = bus.rsp_data;
        status  = bus.rsp_status;
        changes = 0;
        rdy_hi  = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_data !== data || bus.rsp_status !== status) changes++;
            if (bus.cmd_ready) rdy_hi++;
        end
        if (hold > 0) begin
            checkOutput("rsp_hold_stable", 64'(changes), 64'd0);
            checkOutput("cmd_ready_in_resp", 64'(rdy_hi), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        checkOutput("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic [1:0]        s;
        int lat, s0, s1, s2, s3;

        bus.cmd_valid       = 1'b0;
        bus.cmd_op          = 2'b00;
        bus.cmd_addr        = '0;
        bus.cmd_wdata       = '0;
        bus.cmd_mask        = '0;
        bus.avm_waitrequest = 1'b0;
        bus.rsp_ready       = 1'b0;
        for (int i = 0; i < 16; i++) rd_vals[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 64'({bus.cmd_ready, bus.avm_read, bus.avm_write, bus.rsp_valid,
                                       bus.avm_address, bus.rsp_status}), 64'd0);
        checkOutput("reset_data", {bus.avm_writedata, bus.rsp_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);

        $display("[TB] write, no wait states");
        s0 = wr_hi; s1 = wr_done; s2 = bus_bad;
        applyStimulus(2'b00, 2'd0, 32'h5A, 32'h0);
        getResponse(0, d, s, lat);
        checkOutput("wr_latency", 64'(lat), 64'd2);
        checkOutput("wr_data", 64'(d), 64'h5A);
        checkOutput("wr_status", 64'(s), 64'd0);
        checkOutput("wr_write_cycles", 64'(wr_hi - s0), 64'd1);
        checkOutput("wr_accepts", 64'(wr_done - s1), 64'd1);
        checkOutput("wr_bus_ok", 64'(bus_bad - s2), 64'd0);

        $display("[TB] read, latency 1");
        rd_vals[0] = 32'h3C; rd_base = rd_done; s0 = rd_hi;
        applyStimulus(2'b01, 2'd2, 32'h0, 32'h0);
        getResponse(0, d, s, lat);
        checkOutput("rd_latency", 64'(lat), 64'd3);
        checkOutput("rd_data", 64'(d), 64'h3C);
        checkOutput("rd_status", 64'(s), 64'd0);
        checkOutput("rd_read_cycles", 64'(rd_hi - s0), 64'd1);

        $display("[TB] write with 3 wait states");
        s0 = wr_hi; s1 = rsp_count; s2 = bus_bad;
        bus.avm_waitrequest = 1'b1;
        applyStimulus(2'b00, 2'd3, 32'hDEADBEEF, 32'h0);
        repeat (4) @(negedge clk);
        bus.avm_waitrequest = 1'b0;
        getResponse(0, d, s, lat);
        repeat (3) @(negedge clk);
        checkOutput("ws_write_cycles", 64'(wr_hi - s0), 64'd4);
        checkOutput("ws_responses", 64'(rsp_count - s1), 64'd1);
        checkOutput("ws_bus_stable", 64'(bus_bad - s2), 64'd0);
        checkOutput("ws_data", 64'(d), 64'hDEADBEEF);
        checkOutput("ws_status", 64'(s), 64'd0);

`ifdef AVMM_PIO_MASTER_POLL_EN
        $display("[TB] poll, match on the last allowed attempt");
        rd_vals[0] = 32'hF0; rd_vals[1] = 32'hF2; rd_vals[2] = 32'hFE;
        rd_vals[3] = 32'h00; rd_vals[4] = 32'h70; rd_vals[5] = 32'h81;
        rd_base = rd_done; s0 = rd_done; s1 = b2b;
        applyStimulus(2'b10, 2'd1, 32'h01, 32'h01);
        getResponse(0, d, s, lat);
        checkOutput("poll_reads", 64'(rd_done - s0), 64'd6);
        checkOutput("poll_status", 64'(s), 64'd0);
        checkOutput("poll_data", 64'(d), 64'h81);
        checkOutput("poll_idle_gap", 64'(b2b - s1), 64'd0);

        $display("[TB] poll timeout");
        rd_vals[0] = 32'h10; rd_vals[1] = 32'h20; rd_vals[2] = 32'h30;
        rd_vals[3] = 32'h40; rd_vals[4] = 32'h50; rd_vals[5] = 32'h60; rd_vals[6] = 32'h01;
        rd_base = rd_done; s0 = rd_done;
        applyStimulus(2'b10, 2'd1, 32'h01, 32'h01);
        getResponse(0, d, s, lat);
        checkOutput("timeout_reads", 64'(rd_done - s0), 64'd6);
        checkOutput("timeout_status", 64'(s), 64'd1);
        checkOutput("timeout_data", 64'(d), 64'h60);

        $display("[TB] poll, masked match first attempt");
        rd_vals[0] = 32'hA3; rd_base = rd_done; s0 = rd_done;
        applyStimulus(2'b10, 2'd0, 32'hA5, 32'hF0);
        getResponse(0, d, s, lat);
        checkOutput("mask_reads", 64'(rd_done - s0), 64'd1);
        checkOutput("mask_status", 64'(s), 64'd0);
        checkOutput("mask_data", 64'(d), 64'hA3);
`else
        $display("[TB] poll op without poll support");
        s0 = rd_hi; s1 = wr_hi;
        applyStimulus(2'b10, 2'd1, 32'h01, 32'h01);
        getResponse(0, d, s, lat);
        checkOutput("nopoll_latency", 64'(lat), 64'd1);
        checkOutput("nopoll_status", 64'(s), 64'd2);
        checkOutput("nopoll_data", 64'(d), 64'd0);
        checkOutput("nopoll_bus", 64'((rd_hi - s0) + (wr_hi - s1)), 64'd0);
`endif

        $display("[TB] response backpressure");
        rd_vals[0] = 32'h12345678; rd_base = rd_done;
        applyStimulus(2'b01, 2'd2, 32'h0, 32'h0);
        getResponse(10, d, s, lat);
        checkOutput("bp_data", 64'(d), 64'h12345678);
        checkOutput("bp_status", 64'(s), 64'd0);

        $display("[TB] reset during read wait");
        rd_vals[0] = 32'hCAFE; rd_base = rd_done; s1 = rsp_count;
        applyStimulus(2'b01, 2'd2, 32'hAAAA5555, 32'h0);
        @(negedge clk);
        checkOutput("mr_read_issued", 64'(bus.avm_read), 64'd1);
        @(negedge clk);
        checkOutput("mr_rdwait", 64'({bus.avm_read, bus.rsp_valid}), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mr_reset_ctrl", 64'({bus.cmd_ready, bus.avm_read, bus.avm_write, bus.rsp_valid,
                                          bus.avm_address, bus.rsp_status}), 64'd0);
        checkOutput("mr_reset_data", {bus.avm_writedata, bus.rsp_data}, 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("mr_no_response", 64'((rsp_count - s1) + 32'(bus.rsp_valid)), 64'd0);
        checkOutput("mr_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        rd_vals[0] = 32'h77; rd_base = rd_done;
        applyStimulus(2'b01, 2'd1, 32'h0, 32'h0);
        getResponse(0, d, s, lat);
        checkOutput("mr_next_latency", 64'(lat), 64'd3);
        checkOutput("mr_next_data", 64'(d), 64'h77);
        checkOutput("mr_next_status", 64'(s), 64'd0);

        $display("[TB] reserved op");
        s0 = rd_hi; s1 = wr_hi;
        applyStimulus(2'b11, 2'd3, 32'hFFFF, 32'h0);
        getResponse(3, d, s, lat);
        checkOutput("bad_latency", 64'(lat), 64'd1);
        checkOutput("bad_status", 64'(s), 64'd2);
        checkOutput("bad_data", 64'(d), 64'd0);
        checkOutput("bad_bus", 64'((rd_hi - s0) + (wr_hi - s1)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/avmm_pio_master.md
AVMM_PIO_MASTER -- requirements
Module: avmm_pio_master

Interface
REQ-001 Parameter ADDR_W, default 2, Avalon-MM word address width.
REQ-002 Parameter DATA_W, default 32, Avalon-MM data width.
REQ-003 Parameter READ_LATENCY, default 1, fixed cycles from read acceptance to valid avm_readdata (1 to 4).
REQ-004 Parameter POLL_TIMEOUT, default 1024, maximum read attempts per poll command (≥1).
REQ-005 Port clk, input, 1, single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port cmd_valid / cmd_ready, input / output, 1 each, command handshake.
REQ-008 Port cmd_op, input, 2, command: 00 write, 01 read, 10 poll, 11 reserved.
REQ-009 Port cmd_addr, input, ADDR_W; cmd_wdata, input, DATA_W, data for writes and match value for polls; cmd_mask, input, DATA_W, compare mask for polls.
REQ-010 Port avm_address, output, ADDR_W; avm_read / avm_write, output, 1 each; avm_writedata, output, DATA_W.
REQ-011 Port avm_readdata, input, DATA_W; avm_waitrequest, input, 1, stall from the slave (tie low for a PIO slave).
REQ-012 Port rsp_valid / rsp_ready, output / input, 1 each, response handshake.
REQ-013 Port rsp_data, output, DATA_W; rsp_status, output, 2: 00 OK, 01 TIMEOUT, 10 BAD_OP.

Function
REQ-014 The block SHALL implement states IDLE, ISSUE, RDWAIT, RESP; only one transaction SHALL be outstanding at a time.
REQ-015 cmd_ready SHALL be high only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready, and its fields SHALL be latched.
REQ-016 On acceptance: ops 00/01/10 go to ISSUE; op 11 goes directly to RESP with status BAD_OP and rsp_data 0.
REQ-017 In ISSUE, avm_read or avm_write SHALL be asserted (never both), with avm_address and avm_writedata stable, until a cycle with avm_waitrequest low.
REQ-018 A write completing in ISSUE SHALL go to RESP with status OK and rsp_data equal to the written data.
REQ-019 A read completing in ISSUE SHALL go to RDWAIT; avm_readdata SHALL be sampled exactly READ_LATENCY cycles after the accepting cycle.
REQ-020 Read op: after sampling, go to RESP with rsp_data = sample and status OK.
REQ-021 Poll op: if (sample & mask) == (match & mask), go to RESP with status OK; otherwise increment the attempt counter and return to ISSUE, leaving one idle bus cycle between attempts.
REQ-022 Poll op: on the POLL_TIMEOUT-th mismatching sample, go to RESP with status TIMEOUT and rsp_data = last sample.
REQ-023 In RESP, rsp_valid SHALL stay high with stable rsp_data and rsp_status until rsp_ready; on handshake, go to IDLE.
REQ-024 Fastest path SHALL be write accept -> ISSUE 1 cycle -> rsp_valid on the next cycle, with no extra bubbles.

Reset
REQ-025 While reset is high: state IDLE; avm_read, avm_write, rsp_valid and cmd_ready SHALL be 0; avm_address, avm_writedata, rsp_data, rsp_status and the attempt counter SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without a response; a late avm_readdata SHALL be ignored.
REQ-027 cmd_ready SHALL rise on the first clock edge after reset is deasserted.

Configuration
REQ-028 Macro AVMM_PIO_MASTER_POLL_EN: when defined, poll (op 10), the attempt counter and TIMEOUT status SHALL be present.
REQ-029 When the macro is undefined, op 10 SHALL be treated as op 11 (BAD_OP), and the attempt counter SHALL not be synthesized.

Structure
REQ-030 Package avmm_pio_pkg SHALL hold the cmd_op encodings, rsp_status encodings and the state enum typedef.
REQ-031 Sub-module avmm_rd_latency_tracker (shift register of depth READ_LATENCY producing the sample strobe) SHALL be used; all other logic is flat.

Verification
REQ-032 Write op, addr 0, wdata 0x5A, waitrequest low -> avm_write high for 1 cycle with writedata 0x5A; rsp_valid next cycle; status 00; rsp_data 0x5A.
REQ-033 Read op, addr 0, readdata 0x3C, READ_LATENCY 1 -> avm_read for 1 cycle, sample 1 cycle later; rsp_data 0x3C; status 00.
REQ-034 Write op with waitrequest held high for 3 cycles -> avm_write and writedata stable for 4 cycles; exactly 1 response.
REQ-035 Poll op, mask 0x01, match 0x01; readdata 0x00 for 5 attempts, then 0x01 -> 6 reads; status 00; rsp_data 0x01. With POLL_TIMEOUT 4 and readdata held at 0x00 -> 4 reads; status 01.
REQ-036 rsp_ready held low for 10 cycles -> rsp outputs stable; cmd_ready low throughout; op 11 -> status 10, no bus activity.
REQ-037 reset pulsed during RDWAIT -> no response; all outputs 0 on the next cycle; the next command completes normally.
